// File: rtl/bcd_display_scan.sv
// Time-multiplexed 7-segment driver for packed BCD digits with refresh prescaler,
// per-slot blank guard and frame-synchronous update. Optional: LEADING_ZERO_BLANK_EN.
module bcd_display_scan #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick,
  output logic                    pending
);

  localparam int unsigned DW = 4 * NUM_DIGITS;
  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam logic        POL = (ACTIVE_LOW != 0);

  logic [PW-1:0]         prescaler_q, prescaler_d;
  logic [IW-1:0]         scan_idx_q, scan_idx_d;
  logic [DW-1:0]         shadow_q, shadow_d;
  logic [DW-1:0]         display_q, display_d;
  logic                  pending_q, pending_d;
  logic                  frame_tick_q, frame_tick_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  tick_c, wrap_c;
  logic [3:0]            digit_c;
  logic                  digit_blank_c;
  logic [NUM_DIGITS-1:0] lz_mask_c;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  // Prescaler, scan index and shadow/display handoff at the frame boundary.
  always_comb begin
    tick_c       = (prescaler_q == PW'(REFRESH_DIV - 1));
    wrap_c       = tick_c && (scan_idx_q == IW'(NUM_DIGITS - 1));
    prescaler_d  = tick_c ? '0 : prescaler_q + PW'(1);
    scan_idx_d   = scan_idx_q;
    shadow_d     = shadow_q;
    display_d    = display_q;
    pending_d    = pending_q;
    frame_tick_d = wrap_c;
    if (tick_c) begin
      scan_idx_d = (scan_idx_q == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + IW'(1);
    end
    // A load on the wrap edge defers the transfer so one frame never mixes two loads.
    if (load) begin
      shadow_d  = bcd_in;
      pending_d = 1'b1;
    end else if (wrap_c) begin
      display_d = shadow_q;
      pending_d = 1'b0;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Digit i>0 blanks while it and every higher digit are zero; invalid codes count as non-zero.
  always_comb begin
    logic zero_run;
    zero_run  = 1'b1;
    lz_mask_c = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run     = zero_run & (display_q[4*i +: 4] == 4'd0);
      lz_mask_c[i] = zero_run;
    end
  end
`else
  assign lz_mask_c = '0;
`endif

  always_comb begin
    digit_c       = 4'd0;
    digit_blank_c = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx_q == IW'(i)) begin
        digit_c       = display_q[4*i +: 4];
        digit_blank_c = lz_mask_c[i];
      end
    end
  end

  // First cycle of each slot is blanked to suppress ghosting between digits.
  always_comb begin
    seg_d = {7{POL}};
    an_d  = {NUM_DIGITS{POL}};
    if (prescaler_q != '0) begin
      an_d  = (NUM_DIGITS'(1) << scan_idx_q) ^ {NUM_DIGITS{POL}};
      seg_d = (digit_blank_c ? 7'h00 : decode(digit_c)) ^ {7{POL}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler_q  <= '0;
      scan_idx_q   <= '0;
      shadow_q     <= '0;
      display_q    <= '0;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      seg_q        <= {7{POL}};
      an_q         <= {NUM_DIGITS{POL}};
    end else begin
      prescaler_q  <= prescaler_d;
      scan_idx_q   <= scan_idx_d;
      shadow_q     <= shadow_d;
      display_q    <= display_d;
      pending_q    <= pending_d;
      frame_tick_q <= frame_tick_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan: a time-based reference model predicts every
// cycle's outputs for an active-high and an active-low instance driven in parallel.
module tb_bcd_display_scan;

  localparam int unsigned N = 4;
  localparam int unsigned R = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  bcd_in = '0;
  logic         load = 1'b0;
  logic [6:0]   seg0, seg1;
  logic [3:0]   an0, an1;
  logic         ft0, ft1, pend0, pend1;

  bcd_display_scan #(.NUM_DIGITS(N), .REFRESH_DIV(R), .ACTIVE_LOW(0)) dut0 (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load),
    .seg(seg0), .an(an0), .frame_tick(ft0), .pending(pend0));

  bcd_display_scan #(.NUM_DIGITS(N), .REFRESH_DIV(R), .ACTIVE_LOW(1)) dut1 (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load),
    .seg(seg1), .an(an1), .frame_tick(ft1), .pending(pend1));

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] an;
    logic       ft;
    logic       pend;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: edge count since reset release plus the shadow/display digit arrays.
  int         k = 0;
  logic [3:0] shadow_m[N];
  logic [3:0] disp_m[N];
  logic       pend_m = 1'b0;
  logic [6:0] lut[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                          7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  function automatic logic lead_zero(input int idx);
    logic z;
    z = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0) begin
      z = 1'b1;
      for (int j = idx; j < N; j++) if (disp_m[j] != 4'd0) z = 1'b0;
    end
`endif
    return z;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    int   phase, idx;
    logic wrap;
    if (rst) begin
      k = 0;
      pend_m = 1'b0;
      for (int i = 0; i < N; i++) begin shadow_m[i] = 4'd0; disp_m[i] = 4'd0; end
      e.seg = 7'h00; e.an = 4'h0; e.ft = 1'b0; e.pend = 1'b0;
    end else begin
      phase = k % R;
      idx   = (k / R) % N;
      wrap  = (k % (R * N)) == (R * N - 1);
      if (phase == 0) begin
        e.seg = 7'h00; e.an = 4'h0;
      end else begin
        e.an  = 4'(1 << idx);
        e.seg = lead_zero(idx) ? 7'h00 : lut[disp_m[idx]];
      end
      e.ft = wrap;
      if (load) begin
        for (int i = 0; i < N; i++) shadow_m[i] = bcd_in[4*i +: 4];
        pend_m = 1'b1;
      end else if (wrap) begin
        for (int i = 0; i < N; i++) disp_m[i] = shadow_m[i];
        pend_m = 1'b0;
      end
      e.pend = pend_m;
      k = k + 1;
    end
    sb.push_back(e);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: outputs are valid every cycle, compared just after each active edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_empty at %0t: got 0 entries expected 1", $time);
    end else begin
      e = sb.pop_front();
      check("seg_ah",  16'(seg0),  16'(e.seg));
      check("an_ah",   16'(an0),   16'(e.an));
      check("ft_ah",   16'(ft0),   16'(e.ft));
      check("pend_ah", 16'(pend0), 16'(e.pend));
      check("seg_al",  16'(seg1),  16'(e.seg ^ 7'h7F));
      check("an_al",   16'(an1),   16'(e.an ^ 4'hF));
      check("ft_al",   16'(ft1),   16'(e.ft));
      check("pend_al", 16'(pend1), 16'(e.pend));
    end
  end

  task automatic do_load(input logic [15:0] v);
    load   = 1'b1;
    bcd_in = v;
    @(negedge clk);
    load   = 1'b0;
    bcd_in = 16'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(16);
    idle(5);
    do_load(16'h9407);
    idle(40);
    // Align so the load lands on the wrap edge itself.
    for (int w = 0; w < 32 && (k % (R * N)) != (R * N - 1); w++) @(negedge clk);
    do_load(16'h1234);
    idle(40);
    do_load(16'hFA05);
    idle(36);
    do_load(16'h0050);
    idle(36);
    do_load(16'h0000);
    idle(36);
    for (int c = 0; c < 400; c++) begin
      load   = ($urandom_range(0, 7) == 0);
      bcd_in = 16'($urandom);
      @(negedge clk);
    end
    load = 1'b0;
    idle(7);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(24);
    @(posedge clk);
    #2;
    check("sb_drained", 16'(sb.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
